// File: rtl/button_events_pkg.sv
// Shared constants for the push-button event front end: button indices,
// repeat FSM state encoding and the counter width helper.
package button_events_pkg;

   localparam int NUM_BTN   = 4;
   localparam int BTN_INC   = 0;
   localparam int BTN_DEC   = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_DELAY  = 2'd2,
      ST_REPEAT = 2'd3
   } rep_state_e;

   // Width able to hold (largest timing parameter - 1); never narrower than 1.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (m < 2) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/button_debounce_repeat.sv
// One push-button: two-flop synchroniser, debounce counter and the
// press/auto-repeat FSM. event_o is a registered single-cycle event,
// stable_o the debounced level (1 = held).
module button_debounce_repeat
   import button_events_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int REPEAT_DELAY    = 6000000,
   parameter int REPEAT_PERIOD   = 1200000,
   parameter bit REPEAT_EN       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic event_o,
   output logic stable_o
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             sample;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   rep_state_e       state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             event_q, event_d;

   // Synchroniser and debounce: stable flips only after DEBOUNCE_CYCLES
   // consecutive samples that disagree with it.
   always_comb begin
      sync1_d  = btn_n;
      sync2_d  = sync1_q;
      sample   = ~sync2_q;
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      if (sample == stable_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         stable_d = ~stable_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   // Repeat FSM next state. It follows stable_d so the press event is
   // registered on the same edge that the stable level rises.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      event_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (stable_d && !stable_q) begin
               event_d = 1'b1;
               timer_d = DELAY_LOAD;
               state_d = REPEAT_EN ? ST_DELAY : ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!stable_d) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end
         end
         ST_DELAY, ST_REPEAT: begin
            if (!stable_d) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else if (timer_q == '0) begin
               event_d = 1'b1;
               timer_d = PERIOD_LOAD;
               state_d = ST_REPEAT;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   // Synchroniser and debounce registers; sync flops reset to "released".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   // Repeat FSM state, timer and registered event output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         event_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         event_q <= event_d;
      end
   end

   assign event_o  = event_q;
   assign stable_o = stable_q;

endmodule

// File: rtl/button_events.sv
// Four debounced push-buttons turned into single-cycle inc/dec/left/right
// pulses. Events wait in a pending register until downstream accepts and
// are released one per cycle, lowest button index first.
//
// Handshake: accept acts as "ready". A pending bit is the "valid" for its
// event; an event transfers on any cycle where accept=1 and it is the
// lowest pending index, and its pulse appears on the following cycle.
// While accept=0 nothing transfers and pending bits hold.
module button_events
   import button_events_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 120000,
   parameter int          REPEAT_DELAY    = 6000000,
   parameter int          REPEAT_PERIOD   = 1200000,
   parameter logic [3:0]  REPEAT_MASK     = 4'b0011
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn_n,
   input  logic       accept,
   output logic       increment,
   output logic       decrement,
   output logic       left,
   output logic       right,
   output logic [3:0] pressed
);

   logic [3:0] btn_event;
   logic [3:0] btn_stable;
   logic [3:0] grant;
   logic [3:0] pending_q, pending_d;
   logic [3:0] pulse_q, pulse_d;
   logic [3:0] pressed_q, pressed_d;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      button_debounce_repeat #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (REPEAT_MASK[i])
      ) u_btn (
         .clk      (clk),
         .reset    (reset),
         .btn_n    (btn_n[i]),
         .event_o  (btn_event[i]),
         .stable_o (btn_stable[i])
      );
   end

   // Fixed-priority pick of the lowest pending index while downstream accepts.
   always_comb begin
      grant = '0;
      if (accept) begin
         if (pending_q[BTN_INC])        grant[BTN_INC]   = 1'b1;
         else if (pending_q[BTN_DEC])   grant[BTN_DEC]   = 1'b1;
         else if (pending_q[BTN_LEFT])  grant[BTN_LEFT]  = 1'b1;
         else if (pending_q[BTN_RIGHT]) grant[BTN_RIGHT] = 1'b1;
      end
   end

   // Pending/pulse next state: a new event wins over the clear of its own bit.
   always_comb begin
      pending_d = (pending_q & ~grant) | btn_event;
      pulse_d   = grant;
      pressed_d = btn_stable;
   end

   // Pending register, pulse and level output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         pulse_q   <= '0;
         pressed_q <= '0;
      end else begin
         pending_q <= pending_d;
         pulse_q   <= pulse_d;
         pressed_q <= pressed_d;
      end
   end

   assign increment = pulse_q[BTN_INC];
   assign decrement = pulse_q[BTN_DEC];
   assign left      = pulse_q[BTN_LEFT];
   assign right     = pulse_q[BTN_RIGHT];
   assign pressed   = pressed_q;

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events with short timing parameters. A behavioural
// model (sample history window, elapsed-time repeat arithmetic, pending
// bits) predicts every output each cycle; directed scenarios add literal
// timing and pulse-count expectations.
module tb_button_events;

   localparam int         D    = 4;
   localparam int         RD   = 20;
   localparam int         RP   = 8;
   localparam logic [3:0] MASK = 4'b0011;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn_n;
   logic       accept;
   logic       increment, decrement, left, right;
   logic [3:0] pressed;

   button_events #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .REPEAT_MASK     (MASK)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_n     (btn_n),
      .accept    (accept),
      .increment (increment),
      .decrement (decrement),
      .left      (left),
      .right     (right),
      .pressed   (pressed)
   );

   // clock
   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   int         cyc   = 0;
   logic [3:0] seen_pressed;

   // model state
   bit stable_m[4];
   bit ev_m[4];
   bit pend_m[4];
   bit pulse_m[4];
   bit pressed_m[4];
   int press_at[4];
   int mn;
   bit hist[4][$];
   int t_log[4][$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 4; b++) begin
         stable_m[b]  = 1'b0;
         ev_m[b]      = 1'b0;
         pend_m[b]    = 1'b0;
         pulse_m[b]   = 1'b0;
         pressed_m[b] = 1'b0;
         press_at[b]  = 0;
         hist[b].delete();
      end
      mn = 0;
   endtask

   // One clock edge of the behavioural model, using the inputs seen at that edge.
   task automatic model_step();
      bit grant[4];
      bit found;
      bit ns;
      bit alld;
      bit s;
      int idx;
      int el;
      if (reset) return;
      mn++;
      found = 1'b0;
      for (int b = 0; b < 4; b++) begin
         grant[b] = 1'b0;
         if (accept && pend_m[b] && !found) begin
            grant[b] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int b = 0; b < 4; b++) begin
         pressed_m[b] = stable_m[b];
         pend_m[b]    = (pend_m[b] && !grant[b]) || ev_m[b];
         pulse_m[b]   = grant[b];
         // debounce: the level seen now is the raw level two edges ago
         hist[b].push_back(!btn_n[b]);
         if (hist[b].size() > D + 2) void'(hist[b].pop_front());
         alld = 1'b1;
         for (int k = 0; k < D; k++) begin
            idx = int'(hist[b].size()) - 3 - k;
            s   = (idx >= 0) ? hist[b][idx] : 1'b0;
            if (s == stable_m[b]) alld = 1'b0;
         end
         ns = alld ? !stable_m[b] : stable_m[b];
         ev_m[b] = 1'b0;
         if (!stable_m[b] && ns) begin
            ev_m[b]     = 1'b1;
            press_at[b] = mn;
         end else if (stable_m[b] && ns && MASK[b]) begin
            el = mn - press_at[b];
            if (el >= RD && ((el - RD) % RP) == 0) ev_m[b] = 1'b1;
         end
         stable_m[b] = ns;
      end
   endtask

   task automatic compare_cycle();
      logic [3:0] pul;
      logic [3:0] exp_pul;
      logic [3:0] exp_pr;
      pul = {right, left, decrement, increment};
      for (int b = 0; b < 4; b++) begin
         exp_pul[b] = pulse_m[b];
         exp_pr[b]  = pressed_m[b];
      end
      check("pulses", 32'(pul), 32'(exp_pul));
      check("pressed", 32'(pressed), 32'(exp_pr));
      check("onehot", 32'($countones(pul) > 1), 32'd0);
      for (int b = 0; b < 4; b++)
         if (pul[b] === 1'b1) t_log[b].push_back(cyc);
      seen_pressed = seen_pressed | pressed;
   endtask

   // Compare on the falling edge, advance the model on the rising edge,
   // return 1 time unit after it so callers can drive new inputs.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         compare_cycle();
         @(posedge clk);
         cyc++;
         model_step();
         #1;
      end
   endtask

   function automatic int nth_after(input int b, input int t0, input int n);
      int c;
      c = 0;
      foreach (t_log[b][i]) begin
         if (t_log[b][i] > t0) begin
            if (c == n) return t_log[b][i];
            c++;
         end
      end
      return -1;
   endfunction

   function automatic int count_in(input int b, input int t0);
      int c;
      c = 0;
      foreach (t_log[b][i])
         if (t_log[b][i] > t0) c++;
      return c;
   endfunction

   int t, ta, tr, idx;
   int offs[6] = '{0, 20, 28, 36, 44, 52};

   initial begin
      reset  = 1'b1;
      btn_n  = 4'hF;
      accept = 1'b1;
      seen_pressed = '0;
      model_reset();
      #1;
      check("reset_pulses", 32'({right, left, decrement, increment}), 32'd0);
      check("reset_pressed", 32'(pressed), 32'd0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;

      // clean press on inc
      t = cyc;
      btn_n[0] = 1'b0;
      step(12);
      check("press_latency", nth_after(0, t, 0), t + 8);
      check("press_count", count_in(0, t), 1);
      check("press_others", count_in(1, t) + count_in(2, t) + count_in(3, t), 0);
      check("press_level", 32'(pressed), 32'h1);
      btn_n[0] = 1'b1;
      step(12);
      check("release_no_pulse", count_in(0, t), 1);
      check("release_level", 32'(pressed), 32'h0);

      // bounce on dec
      seen_pressed = '0;
      t = cyc;
      repeat (5) begin
         btn_n[1] = 1'b0;
         step(2);
         btn_n[1] = 1'b1;
         step(2);
      end
      step(10);
      check("bounce_pulses", count_in(1, t), 0);
      check("bounce_level", 32'(seen_pressed[1]), 32'd0);

      // auto-repeat on dec
      t = cyc;
      btn_n[1] = 1'b0;
      step(60);
      btn_n[1] = 1'b1;
      step(15);
      check("repeat_count", count_in(1, t), 6);
      check("repeat_first", nth_after(1, t, 0), t + 8);
      for (int k = 1; k < 6; k++)
         check($sformatf("repeat_gap%0d", k), nth_after(1, t, k) - nth_after(1, t, 0), offs[k]);

      // held left: no repeat enabled
      t = cyc;
      btn_n[2] = 1'b0;
      step(60);
      btn_n[2] = 1'b1;
      step(15);
      check("left_count", count_in(2, t), 1);

      // blocked then released: inc and right together
      accept = 1'b0;
      t = cyc;
      btn_n = 4'b0110;
      step(30);
      ta = cyc;
      accept = 1'b1;
      step(10);
      check("blocked_inc", nth_after(0, t, 0), ta + 1);
      check("blocked_right", nth_after(3, t, 0), ta + 2);
      btn_n = 4'hF;
      step(15);

      // coalesce while blocked
      accept = 1'b0;
      t = cyc;
      btn_n[0] = 1'b0;
      step(60);
      btn_n[0] = 1'b1;
      step(15);
      ta = cyc;
      accept = 1'b1;
      step(10);
      check("coalesce_count", count_in(0, t), 1);
      check("coalesce_time", nth_after(0, t, 0), ta + 1);

      // async reset while repeating
      btn_n[0] = 1'b0;
      accept = 1'b1;
      step(40);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("midreset_pulses", 32'({right, left, decrement, increment}), 32'd0);
      check("midreset_pressed", 32'(pressed), 32'd0);
      step(1);
      #2 reset = 1'b0;
      tr = cyc;
      step(12);
      check("postreset_latency", nth_after(0, tr, 0), tr + 8);
      check("postreset_count", count_in(0, tr), 1);
      btn_n = 4'hF;
      step(15);

      // random stimulus against the model
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 9) < 6) begin
            idx = $urandom_range(0, 3);
            btn_n[idx] = ~btn_n[idx];
         end
         accept = ($urandom_range(0, 3) != 0);
         step($urandom_range(1, 14));
      end
      btn_n  = 4'hF;
      accept = 1'b1;
      step(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Upstream stage of the SPI LED register. Turns four raw, bouncing, active-low push-buttons into single-cycle increment/decrement/left/right event pulses.
- Synchronises and debounces each button, generates optional auto-repeat while a button is held, and queues events while the LED register cannot accept them (SPI transaction in progress).
- Arbitrates so that at most one event pulse is asserted per cycle, so lower-priority events are never silently masked downstream.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive cycles a synchronised level must differ from the stable level before the stable level flips (10 ms at 12 MHz); must be >= 2.
- REPEAT_DELAY, 6000000, cycles from the press event to the first repeat event (500 ms).
- REPEAT_PERIOD, 1200000, cycles between subsequent repeat events (100 ms).
- REPEAT_MASK, 4'b0011, per-button auto-repeat enable; bit index is the button index.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_n  input  4  raw asynchronous buttons, low = pressed; [0]=inc, [1]=dec, [2]=left, [3]=right
- accept  input  1  high = downstream can take events; tied to the SPI chip-select (high when idle)
- increment  output  1  registered single-cycle event pulse
- decrement  output  1  registered single-cycle event pulse
- left  output  1  registered single-cycle event pulse
- right  output  1  registered single-cycle event pulse
- pressed  output  4  debounced level per button, 1 = held

Behaviour:
- Reset (async assert, sync release):
  - sync flops = 1;
  - stable levels = released;
  - debounce and repeat counters = 0;
  - FSMs = IDLE;
  - pending = 0;
  - all pulse outputs = 0;
  - pressed = 0.
- Synchroniser: 2 flops per bit. The sample is the inverted second flop (1 = pressed).
- Debounce, per button:
  - Counter clears on any cycle where sample == stable.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the sample still differs, stable flips and the counter clears.
  - A single-cycle mismatch never flips stable.
- pressed = stable, registered. There are no release events.
- Repeat FSM, per button:
  - IDLE: on a stable 0->1 transition, raise press event, load timer = REPEAT_DELAY-1, go to DELAY if REPEAT_MASK bit set, else HOLD.
  - DELAY: decrement timer. At 0 with stable=1, raise repeat event, load REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT: decrement timer. At 0, raise repeat event and reload.
  - HOLD / DELAY / REPEAT: stable=0 -> IDLE in the same cycle, no event, timer value discarded.
- Pending register, 4 bits:
  - A raised event sets its pending bit the next cycle.
  - An event arriving while its bit is already set coalesces (one pulse only).
- Arbiter:
  - When accept=1 and pending != 0, select the lowest set index (inc > dec > left > right).
  - The next cycle, assert exactly that output for one cycle and clear that pending bit.
  - When accept=0, no pulses; pending bits are held.
  - An event raised in the same cycle its bit is cleared re-sets the bit (clear loses to set).
- Latency: DEBOUNCE_CYCLES+4 clock edges from the first edge sampling btn_n low, to the pulse being high. This assumes accept=1 and no higher-priority pending bit.
- Invariant: increment+decrement+left+right <= 1 every cycle.
- Reset mid-hold: all state cleared. A button still held after reset release is seen as a new press, producing one event after full debounce.

Decomposition:
- Shared package/constants:
  - button indices BTN_INC=0, BTN_DEC=1, BTN_LEFT=2, BTN_RIGHT=3;
  - FSM state encoding IDLE/HOLD/DELAY/REPEAT (2 bits);
  - counter width helper: $clog2 of the max of the three timing parameters.
- One sub-module, button_debounce_repeat: per-button synchroniser, debounce counter, repeat FSM and timer. It has an event output and a stable output, and is instantiated 4 times with its REPEAT_MASK bit.
- Top level holds the pending register, arbiter and output registers.

Test Plan (bench params DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Clean press: btn_n[0] driven low and held, accept=1 -> increment high exactly 1 cycle, 8 edges after the first low sample; pressed[0]=1; no other pulses.
- Bounce reject: btn_n[1] toggles low/high every 2 cycles for 20 cycles, then stays high -> zero pulses, pressed[1] stays 0.
- Auto-repeat: btn_n[1] held 60 cycles -> decrement at T0, T0+20, T0+28, T0+36, T0+44, T0+52 (6 pulses). Same hold on btn_n[2] -> exactly 1 left pulse.
- Blocked then released: accept=0, then press inc and right simultaneously; raise accept after 30 cycles -> increment in the 2nd cycle after accept rises, right in the next cycle, never both high.
- Coalesce: accept=0, hold btn_n[0] for 60 cycles (several repeat events), release, then accept=1 -> exactly one increment pulse.
- Async reset: assert reset mid-REPEAT for 1 cycle off a clock edge -> outputs and pressed drop to 0 immediately. With the button still held, the first post-reset increment comes DEBOUNCE_CYCLES+4 edges after reset release.
